// File: rtl/tone_square_gen_if.sv
// tone_square_gen_if: bus between the note-select front end and the tone
// generator back end.
//   counter_value  : half-period reload from the 12-button note mux (0 = no note)
//   octave_shift   : right-shift applied to the reload (0..3 octaves up)
//   speaker        : square-wave tone output
//   note_active    : high while the generator is running
//   half_tick      : one-cycle pulse on every speaker edge
//   active_reload  : effective half-period currently generated (0 when idle)
// Modports: master drives the note request, slave is the tone generator.
interface tone_square_gen_if #(
  parameter int unsigned WIDTH = 20
);
  logic [WIDTH-1:0] counter_value;
  logic [1:0]       octave_shift;
  logic             speaker;
  logic             note_active;
  logic             half_tick;
  logic [WIDTH-1:0] active_reload;

  modport master (
    output counter_value, octave_shift,
    input  speaker, note_active, half_tick, active_reload
  );

  modport slave (
    input  counter_value, octave_shift,
    output speaker, note_active, half_tick, active_reload
  );
endinterface

// File: rtl/tone_square_gen.sv
// tone_square_gen: sequential back end of the note-select path. Turns a
// half-period reload value (in clk cycles) into a glitch-free square wave;
// pitch changes and stops take effect only at half-period boundaries.
// Ports:
//   clk    : system clock
//   reset  : synchronous, active-high reset
//   bus    : tone_square_gen_if.slave (counter_value, octave_shift in;
//            speaker, note_active, half_tick, active_reload out)
// Parameters:
//   WIDTH      : reload path width
//   MIN_RELOAD : smallest effective half-period; anything below is silence
// Build option:
//   TONE_SQUARE_GEN_OCTAVE_EN : when defined, octave_shift is sampled and the
//   reload is right-shifted by it; otherwise octave_shift is ignored.
module tone_square_gen #(
  parameter int unsigned WIDTH      = 20,
  parameter int unsigned MIN_RELOAD = 2
) (
  input logic              clk,
  input logic              reset,
  tone_square_gen_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] cv_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] reload_q;
  logic             speaker_q;
  logic             tick_q;
  logic [WIDTH-1:0] eff;
  logic             eff_valid;

`ifdef TONE_SQUARE_GEN_OCTAVE_EN
  logic [1:0] sh_q;

  always_ff @(posedge clk) begin
    if (reset) sh_q <= '0;
    else       sh_q <= bus.octave_shift;
  end

  always_comb eff = cv_q >> sh_q;
`else
  logic unused_octave;
  assign unused_octave = ^bus.octave_shift;

  always_comb eff = cv_q;
`endif

  assign eff_valid = (eff >= WIDTH'(MIN_RELOAD));

  // cnt holds remaining cycles minus one, so a level loaded with eff-1
  // lasts exactly eff cycles before the terminal (cnt == 0) edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cv_q      <= '0;
      cnt_q     <= '0;
      reload_q  <= '0;
      speaker_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cv_q   <= bus.counter_value;
      tick_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (eff_valid) begin
            state_q   <= RUN;
            speaker_q <= 1'b1;
            cnt_q     <= eff - 1'b1;
            reload_q  <= eff;
            tick_q    <= 1'b1;
          end
        end
        RUN: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (eff_valid) begin
            speaker_q <= ~speaker_q;
            tick_q    <= 1'b1;
            cnt_q     <= eff - 1'b1;
            reload_q  <= eff;
          end else begin
            // Stopping after a low level produces no edge, hence no tick.
            state_q   <= IDLE;
            speaker_q <= 1'b0;
            tick_q    <= speaker_q;
            cnt_q     <= '0;
            reload_q  <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.speaker       = speaker_q;
  assign bus.note_active   = (state_q == RUN);
  assign bus.half_tick     = tick_q;
  assign bus.active_reload = reload_q;

endmodule

// File: tb/tb_tone_square_gen.sv
// tb_tone_square_gen: scoreboard bench for tone_square_gen. A behavioural
// model steps on each rising edge and queues the expected outputs; a checker
// pops and compares them on the falling edge.
module tb_tone_square_gen;

  localparam int unsigned WIDTH      = 20;
  localparam int unsigned MIN_RELOAD = 2;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  tone_square_gen_if #(.WIDTH(WIDTH)) bus ();

  tone_square_gen #(
    .WIDTH      (WIDTH),
    .MIN_RELOAD (MIN_RELOAD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic             spk;
    logic             act;
    logic             tick;
    logic [WIDTH-1:0] rel;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Reference model: levels counted as cycles remaining in the half-period.
  logic [WIDTH-1:0] m_cv = '0;
  logic [1:0]       m_sh = '0;
  logic             m_run = 1'b0;
  logic             m_spk = 1'b0;
  logic             m_tick = 1'b0;
  logic [WIDTH-1:0] m_len = '0;
  int               m_left = 0;

  always @(posedge clk) begin
    logic [WIDTH-1:0] e;
    logic             ok;
`ifdef TONE_SQUARE_GEN_OCTAVE_EN
    e = m_cv >> m_sh;
`else
    e = m_cv;
`endif
    ok = (e >= WIDTH'(MIN_RELOAD));
    if (reset) begin
      m_run = 0; m_spk = 0; m_tick = 0; m_len = '0; m_left = 0;
      m_cv = '0; m_sh = '0;
    end else begin
      m_tick = 0;
      if (!m_run) begin
        if (ok) begin
          m_run = 1; m_spk = 1; m_tick = 1; m_len = e; m_left = int'(e);
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          if (ok) begin
            m_spk = !m_spk; m_tick = 1; m_len = e; m_left = int'(e);
          end else begin
            m_tick = m_spk; m_spk = 0; m_run = 0; m_len = '0;
          end
        end
      end
      m_cv = bus.counter_value;
      m_sh = bus.octave_shift;
    end
    exp_q.push_back('{spk: m_spk, act: m_run, tick: m_tick, rel: m_len});
  end

  always @(negedge clk) begin
    exp_t x;
    if (exp_q.size() != 0) begin
      x = exp_q.pop_front();
      check_val("speaker",       32'(bus.speaker),       32'(x.spk));
      check_val("note_active",   32'(bus.note_active),   32'(x.act));
      check_val("half_tick",     32'(bus.half_tick),     32'(x.tick));
      check_val("active_reload", 32'(bus.active_reload), 32'(x.rel));
    end
  end

  // Rising edges from reset release until speaker goes high; must be 2.
  task automatic check_start_latency(input string tag);
    int lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (bus.speaker === 1'b1) begin
        lat = i;
        break;
      end
    end
    check_val(tag, 32'(lat), 32'd2);
    @(negedge clk);
  endtask

  task automatic wait_tick(input int bound, input string tag);
    logic seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (bus.half_tick === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check_val(tag, 32'(seen), 32'd1);
  endtask

  task automatic wait_speaker_high(input int bound, input string tag);
    logic seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (bus.speaker === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check_val(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    bus.counter_value = 20'd5;
    bus.octave_shift  = 2'd0;

    // Reset and idle, then tone at 5
    repeat (3) @(negedge clk);
    check_val("reset_speaker", 32'(bus.speaker), 32'd0);
    check_val("reset_reload",  32'(bus.active_reload), 32'd0);
    reset = 1'b0;
    check_start_latency("start_latency");
    repeat (22) @(negedge clk);

    // Pitch change mid-period
    wait_tick(12, "tick_before_pitch");
    repeat (2) @(negedge clk);
    bus.counter_value = 20'd3;
    repeat (20) @(negedge clk);
    check_val("pitch_reload", 32'(bus.active_reload), 32'd3);

    // Stop from a high level
    bus.counter_value = 20'd4;
    repeat (12) @(negedge clk);
    wait_speaker_high(12, "speaker_high_before_stop");
    repeat (1) @(negedge clk);
    bus.counter_value = 20'd0;
    repeat (15) @(negedge clk);
    check_val("stopped_active", 32'(bus.note_active), 32'd0);

    // Octave shift and minimum clamp
    bus.counter_value = 20'd28409;
    bus.octave_shift  = 2'd2;
    repeat (20) @(negedge clk);
`ifdef TONE_SQUARE_GEN_OCTAVE_EN
    check_val("octave_reload", 32'(bus.active_reload), 32'd7102);
`else
    check_val("octave_reload", 32'(bus.active_reload), 32'd28409);
`endif
    reset = 1'b1;
    bus.counter_value = 20'd3;
    bus.octave_shift  = 2'd1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
`ifdef TONE_SQUARE_GEN_OCTAVE_EN
    check_val("clamp_active", 32'(bus.note_active), 32'd0);
`else
    check_val("clamp_active", 32'(bus.note_active), 32'd1);
`endif

    // Reset mid-run with speaker high, then restart
    bus.octave_shift  = 2'd0;
    bus.counter_value = 20'd6;
    repeat (20) @(negedge clk);
    wait_speaker_high(14, "speaker_high_before_reset");
    reset = 1'b1;
    @(negedge clk);
    check_val("midrun_reset_speaker", 32'(bus.speaker), 32'd0);
    check_val("midrun_reset_active",  32'(bus.note_active), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check_start_latency("restart_latency");
    repeat (15) @(negedge clk);

    // Glitch immunity at 8
    bus.counter_value = 20'd8;
    repeat (20) @(negedge clk);
    wait_tick(18, "tick_before_glitch");
    repeat (3) @(negedge clk);
    bus.counter_value = 20'd2;
    @(negedge clk);
    bus.counter_value = 20'd8;
    repeat (40) @(negedge clk);
    check_val("glitch_reload", 32'(bus.active_reload), 32'd8);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tone_square_gen.md
# tone_square_gen

Sequential back end of the note-select path. It consumes the combinational reload value produced by the 12-button note mux and generates the audible square wave for the speaker pin. Each reload value is a half-period length in clock cycles, and the block can optionally shift it by octave. Pitch changes take effect only at half-period boundaries, so the output has no runt pulses or glitches.

## Interface
- WIDTH, 20, width of the reload path (matches the mux reload output)
- MIN_RELOAD, 2, smallest effective half-period accepted; anything below it is treated as silence
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- counter_value  input  WIDTH  half-period reload from the note mux; 0 = no note
- octave_shift  input  2  right-shift applied to counter_value (0..3 octaves up)
- speaker  output  1  square-wave tone output
- note_active  output  1  high while the FSM is in RUN
- half_tick  output  1  one-cycle pulse on every speaker edge
- active_reload  output  WIDTH  effective half-period currently being generated; 0 when idle

## Operation
- Input stage:
  - counter_value and octave_shift are registered once into sample registers, because the mux output is asynchronous to clk.
  - eff = sampled value >> sampled shift.
  - eff is valid when eff >= MIN_RELOAD.
- Down-counter cnt is WIDTH bits wide.
- FSM states:
  - IDLE: speaker = 0, cnt = 0, active_reload = 0.
    - If eff is valid, the next edge enters RUN with speaker <= 1, cnt <= eff-1, active_reload <= eff and half_tick <= 1.
  - RUN, cnt != 0: cnt decrements by 1. Input changes are ignored except for sampling.
  - RUN, cnt == 0 (terminal), with eff valid: speaker toggles, half_tick <= 1, cnt <= eff-1, active_reload <= eff.
    - A new pitch takes effect only here.
  - RUN, cnt == 0 (terminal), with eff invalid: speaker <= 0, half_tick <= 1 only if speaker was 1, state <= IDLE, active_reload <= 0.
    - The current half-period always completes; there is no mid-period cut.
- note_active = (state == RUN).
- Widths: the shift is logical with zero fill. The eff-1 subtraction cannot underflow because eff >= MIN_RELOAD >= 1 whenever it is used.
- Boundary rules:
  - If a change lands in the sample register on the terminal cycle, it is used at that terminal.
  - An input glitch that returns to its original value before the terminal has no effect.
  - If counter_value is held constant, the output is a steady 50% duty wave.

## Timing
- Reset values: speaker 0, note_active 0, half_tick 0, active_reload 0, cnt 0, sample registers 0, state IDLE.
- Reset applies on the next clk edge from any state, including mid-half-period; no partial wave is emitted after it.
- Start latency: counter_value changes before edge N, is sampled at edge N, and speaker rises at edge N+1. This is 2 edges.
- Each speaker level lasts exactly eff clk cycles. Full period = 2*eff cycles.
- Pitch change latency: from the sample edge to the next terminal count, at most eff_old + 1 cycles.
- Stop latency: the current half-period completes, then speaker = 0 and note_active = 0 at that terminal edge.
- half_tick is high for exactly one cycle, coincident with the cycle in which the new speaker level is first visible.

## Configuration
- TONE_SQUARE_GEN_OCTAVE_EN defined:
  - octave_shift is sampled and applied as described above.
- TONE_SQUARE_GEN_OCTAVE_EN undefined:
  - octave_shift is ignored and its sample register is removed.
  - eff = sampled counter_value.
  - All other behaviour is identical.

## Test plan
- Reset and idle: hold reset 3 cycles with counter_value = 5, then release.
  - Required: speaker rises 2 edges after release.
  - Required: levels of 5 cycles each, half_tick every 5 cycles, active_reload = 5.
- Pitch change: running at 5, change to 3 mid-period.
  - Required: the current high/low level finishes its full 5 cycles.
  - Required: subsequent levels are 3 cycles long and active_reload = 3 from that terminal edge.
- Stop: running at 4, set counter_value = 0 while speaker = 1 and cnt = 2.
  - Required: speaker stays 1 for the remaining cycles, then goes 0 with a final half_tick.
  - Required: note_active = 0 at that edge, followed by no further ticks.
- Octave and min clamp, with macro defined:
  - counter_value = 28409, octave_shift = 2: required active_reload = 7102.
  - counter_value = 3, octave_shift = 1: eff = 1 < MIN_RELOAD, so required to stay in IDLE with speaker 0.
- Reset mid-run: assert reset while running at 6 with speaker = 1.
  - Required: next edge gives speaker 0, note_active 0, active_reload 0.
  - Required: after release with the input still 6, restart with 2-edge latency.
- Glitch immunity: running at 8, pulse counter_value to 2 for 1 cycle away from the terminal count.
  - Required: period is unchanged at 8/8.
